// File: rtl/sched_pkg.sv
// Shared types and helpers for the count_sched round-robin interval scheduler.
package sched_pkg;

  // Scheduler states: waiting for a request, running the counter, reporting completion.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Width of a requester ID; never below one bit so ports stay legal.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sched_counter.sv
// Shared interval up-counter: synchronous clear, count enable, terminal-value compare.
module sched_counter
  import sched_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_val,
  output logic         o_last
);

  // Counter register: clear wins over enable, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_val <= '0;
    end else if (i_clear) begin
      o_val <= '0;
    end else if (i_enable) begin
      o_val <= o_val + W'(1);
    end
  end

  assign o_last = (o_val == i_term);

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one interval counter among NREQ requesters.
// A winner is picked in IDLE, the counter runs 0..len-1 in COUNT, and DONE
// pulses o_done tagged with the winner's ID before returning to IDLE.
module count_sched
  import sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_len,
  output logic [NREQ-1:0]   o_grant,
  output logic [IDW-1:0]    o_gnt_id,
  output logic [W-1:0]      o_val,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDW-1:0]    o_done_id
);

  state_t         state;
  logic [IDW-1:0] last_id;
  logic [W-1:0]   len_q;

  logic [IDW-1:0] pick;
  logic           pick_valid;
  logic [W-1:0]   pick_len;

  logic           abort;
  logic           cnt_last;
  logic           cnt_clear;
  logic           cnt_enable;

  // Round-robin search: first requester set after last_id, wrapping modulo NREQ.
  always_comb begin
    logic [IDW-1:0] idx;
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDW'((int'(last_id) + off) % NREQ);
      if (!pick_valid && i_req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Select the winner's run length from the packed length bus.
  always_comb begin
    pick_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IDW'(k)) pick_len = i_len[k*W +: W];
    end
  end

  // Counter control: run only in COUNT until the terminal value, clear everywhere else.
  always_comb begin
    abort      = (state == S_COUNT) && !i_req[o_gnt_id];
    cnt_clear  = (state != S_COUNT) || abort;
    cnt_enable = (state == S_COUNT) && !cnt_last;
  end

  sched_counter #(.W(W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (cnt_clear),
    .i_enable (cnt_enable),
    .i_term   (len_q - W'(1)),
    .o_val    (o_val),
    .o_last   (cnt_last)
  );

  // Scheduler FSM with registered grant and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last_id   <= IDW'(NREQ - 1);
      len_q     <= '0;
      o_grant   <= '0;
      o_gnt_id  <= '0;
      o_done    <= 1'b0;
      o_done_id <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            len_q    <= pick_len;
            o_gnt_id <= pick;
            o_grant  <= NREQ'(1) << pick;
            if (pick_len == '0) begin
              state     <= S_DONE;
              o_done    <= 1'b1;
              o_done_id <= pick;
            end else begin
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          // A dropped request cancels the run even on its final count.
          if (abort) begin
            state    <= S_IDLE;
            last_id  <= o_gnt_id;
            o_grant  <= '0;
            o_gnt_id <= '0;
          end else if (cnt_last) begin
            state     <= S_DONE;
            o_done    <= 1'b1;
            o_done_id <= o_gnt_id;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          last_id   <= o_gnt_id;
          o_grant   <= '0;
          o_gnt_id  <= '0;
          o_done    <= 1'b0;
          o_done_id <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule
